// File: rtl/cv32e40x_pkg.sv
// ============================================================================
//  Module      : cv32e40x_pkg
//  Description : Shared types for the cv32e40x divider slice.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cv32e40x_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage : cv32e40x_pkg

`default_nettype wire

// File: rtl/cv32e40x_div_seq.sv
// ============================================================================
//  Module      : cv32e40x_div_seq
//  Description : Sequential radix-2 restoring divider (DIV/DIVU/REM/REMU),
//                one quotient bit per cycle, valid/ready in and out, killable.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40x_div_seq
    import cv32e40x_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             div_signed_i,
    input  logic             div_rem_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int               CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]    c_CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_MIN      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_ONES     = {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v, input logic en);
        return (en && v[WIDTH-1]) ? f_neg(v) : v;
    endfunction

    div_state_e       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_b;
    logic             r_a_neg;
    logic             r_q_neg;
    logic             r_rem_sel;
    logic             r_dz;

    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_dz;
    logic             w_ovf;
    logic             w_early;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH:0]   w_rem_tmp;
    logic             w_ge;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    assign w_a_neg = div_signed_i & op_a_i[WIDTH-1];
    assign w_b_neg = div_signed_i & op_b_i[WIDTH-1];
    assign w_dz    = (op_b_i == '0);
    assign w_ovf   = div_signed_i & (op_a_i == c_MIN) & (op_b_i == c_ONES);
    assign w_early = EARLY_OUT & (w_dz | w_ovf);
    assign w_a_abs = f_abs(op_a_i, div_signed_i);

    // The guard bit of rem never sets (rem < |b|); folding it in keeps the compare total.
    assign w_rem_tmp = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
    assign w_ge      = r_rem[WIDTH] | (w_rem_tmp >= {1'b0, r_b});
    assign w_rem_nxt = w_ge ? (w_rem_tmp - {1'b0, r_b}) : w_rem_tmp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DIV_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_b       <= '0;
            r_a_neg   <= 1'b0;
            r_q_neg   <= 1'b0;
            r_rem_sel <= 1'b0;
            r_dz      <= 1'b0;
        end else if (kill_i) begin
            r_state <= DIV_IDLE;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (valid_i) begin
                        r_b       <= f_abs(op_b_i, div_signed_i);
                        r_a_neg   <= w_a_neg;
                        r_q_neg   <= w_a_neg ^ w_b_neg;
                        r_rem_sel <= div_rem_i;
                        r_dz      <= w_dz;
                        if (w_early) begin
                            // Preload the final quotient/remainder magnitudes directly.
                            r_dvd   <= w_dz ? c_ONES : c_MIN;
                            r_rem   <= w_dz ? {1'b0, w_a_abs} : '0;
                            r_state <= DIV_DONE;
                        end else begin
                            r_dvd   <= w_a_abs;
                            r_rem   <= '0;
                            r_cnt   <= c_CNT_LAST;
                            r_state <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                    if (r_cnt == '0) begin
                        r_state <= DIV_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DIV_DONE: begin
                    if (ready_i) begin
                        r_state <= DIV_IDLE;
                    end
                end
                default: r_state <= DIV_IDLE;
            endcase
        end
    end

    // Divide-by-zero quotient is all-ones regardless of the operand signs.
    assign w_quo = r_dz ? c_ONES : (r_q_neg ? f_neg(r_dvd) : r_dvd);
    assign w_rem = r_a_neg ? f_neg(r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];

    assign ready_o  = (r_state == DIV_IDLE);
    assign valid_o  = (r_state == DIV_DONE);
    assign result_o = r_rem_sel ? w_rem : w_quo;

endmodule : cv32e40x_div_seq

`default_nettype wire

// File: tb/tb_cv32e40x_div_seq.sv
// ============================================================================
//  Module      : tb_cv32e40x_div_seq
//  Description : Self-checking bench for cv32e40x_div_seq, EARLY_OUT=1 and 0 side by side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cv32e40x_div_seq;

    localparam logic [31:0] c_MIN  = 32'h8000_0000;
    localparam logic [31:0] c_ONES = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        kill_i;
    logic        valid_i;
    logic        div_signed_i;
    logic        div_rem_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        ready_i;

    logic        ready_e, valid_e, ready_l, valid_l;
    logic [31:0] result_e, result_l;

    int n_checks = 0;
    int n_errors = 0;

    cv32e40x_div_seq #(.WIDTH(32), .EARLY_OUT(1'b1)) u_dut_early (
        .clk          (clk),
        .rst          (rst),
        .kill_i       (kill_i),
        .valid_i      (valid_i),
        .ready_o      (ready_e),
        .div_signed_i (div_signed_i),
        .div_rem_i    (div_rem_i),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .valid_o      (valid_e),
        .ready_i      (ready_i),
        .result_o     (result_e)
    );

    cv32e40x_div_seq #(.WIDTH(32), .EARLY_OUT(1'b0)) u_dut_late (
        .clk          (clk),
        .rst          (rst),
        .kill_i       (kill_i),
        .valid_i      (valid_i),
        .ready_o      (ready_l),
        .div_signed_i (div_signed_i),
        .div_rem_i    (div_rem_i),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .valid_o      (valid_l),
        .ready_i      (ready_i),
        .result_o     (result_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics from plain arithmetic.
    function automatic logic [31:0] ref_div(input logic s, input logic r,
                                            input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0)                              return r ? a : c_ONES;
        if (s && a == c_MIN && b == c_ONES)          return r ? 32'd0 : c_MIN;
        if (s) return r ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return r ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat_early(input logic s, input logic [31:0] a, input logic [31:0] b);
        return ((b == 32'd0) || (s && a == c_MIN && b == c_ONES)) ? 1 : 33;
    endfunction

    // Issue one request with ready_i=1 and check both DUTs' result and latency.
    task automatic run_op(input logic s, input logic r, input logic [31:0] a, input logic [31:0] b);
        int          lat_e, lat_l;
        logic [31:0] res_e, res_l;
        @(negedge clk);
        chk("ready_before_e", 32'(ready_e), 32'd1);
        chk("ready_before_l", 32'(ready_l), 32'd1);
        div_signed_i = s; div_rem_i = r; op_a_i = a; op_b_i = b; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        op_a_i = $urandom; op_b_i = $urandom; div_signed_i = $urandom_range(0, 1); div_rem_i = $urandom_range(0, 1);
        lat_e = -1; lat_l = -1; res_e = '0; res_l = '0;
        for (int k = 1; k <= 40; k++) begin
            if (lat_e < 0 && valid_e) begin lat_e = k; res_e = result_e; end
            if (lat_l < 0 && valid_l) begin lat_l = k; res_l = result_l; end
            if (lat_e >= 0 && lat_l >= 0) break;
            @(negedge clk);
        end
        chk("result_early", res_e, ref_div(s, r, a, b));
        chk("result_late",  res_l, ref_div(s, r, a, b));
        chk("lat_early", 32'(lat_e), 32'(ref_lat_early(s, a, b)));
        chk("lat_late",  32'(lat_l), 32'd33);
    endtask

    // Start a normal-length op, then abort it at CALC cycle n via kill or reset.
    task automatic abort_op(input int n, input logic use_rst);
        logic seen;
        @(negedge clk);
        div_signed_i = 1'b0; div_rem_i = 1'b0; op_a_i = 32'd1000; op_b_i = 32'd3; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        for (int k = 1; k < n; k++) @(negedge clk);
        if (use_rst) rst = 1'b1; else kill_i = 1'b1;
        @(negedge clk);
        rst = 1'b0; kill_i = 1'b0;
        chk(use_rst ? "rst_ready_e" : "kill_ready_e", 32'(ready_e), 32'd1);
        chk(use_rst ? "rst_valid_l" : "kill_valid_l", 32'(valid_l), 32'd0);
        if (use_rst) chk("rst_result_e", result_e, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (valid_e || valid_l) seen = 1'b1;
            @(negedge clk);
        end
        chk(use_rst ? "rst_no_valid" : "kill_no_valid", 32'(seen), 32'd0);
        run_op(1'b0, 1'b0, c_ONES, 32'd1);
    endtask

    initial begin
        logic        s, r;
        logic [31:0] a, b;
        rst = 1'b1; kill_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        div_signed_i = 1'b0; div_rem_i = 1'b0; op_a_i = '0; op_b_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_ready",  32'(ready_e), 32'd1);
        chk("reset_valid",  32'(valid_e), 32'd0);
        chk("reset_result", result_e, 32'd0);
        chk("reset_result_l", result_l, 32'd0);

        // Directed cases
        run_op(1'b0, 1'b0, 32'd100, 32'd7);
        run_op(1'b0, 1'b1, 32'd100, 32'd7);
        run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_op(1'b0, 1'b0, 32'h1234, 32'd0);
        run_op(1'b1, 1'b1, 32'h1234, 32'd0);
        run_op(1'b1, 1'b0, 32'hFFFF_FFF0, 32'd0);
        run_op(1'b1, 1'b1, 32'hFFFF_FFF0, 32'd0);
        run_op(1'b1, 1'b0, c_MIN, c_ONES);
        run_op(1'b1, 1'b1, c_MIN, c_ONES);
        run_op(1'b0, 1'b0, c_MIN, c_ONES);

        // Backpressure: hold the result 5 cycles, pulse valid_i in the window
        @(negedge clk);
        ready_i = 1'b0;
        div_signed_i = 1'b0; div_rem_i = 1'b0; op_a_i = 32'd100; op_b_i = 32'd7; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        for (int k = 1; k < 33; k++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid",  32'(valid_e & valid_l), 32'd1);
            chk("bp_result", result_e, 32'd14);
            chk("bp_result_l", result_l, 32'd14);
            chk("bp_ready",  32'(ready_e | ready_l), 32'd0);
            valid_i = (k == 2);
            op_a_i = 32'd55; op_b_i = 32'd5;
            @(negedge clk);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        run_op(1'b0, 1'b1, 32'd55, 32'd4);

        abort_op(10, 1'b0);
        abort_op(5, 1'b1);

        // Randomized traffic with biased corner operands
        for (int i = 0; i < 40; i++) begin
            s = $urandom_range(0, 1);
            r = $urandom_range(0, 1);
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       begin a = c_MIN; b = c_ONES; end
                3:       b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            run_op(s, r, a, b);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_cv32e40x_div_seq

`default_nettype wire
